// File: rtl/instr_encoder_pkg.sv
// Shared instruction-type constants: type codes, format codes, opcodes and
// immediate range limits, common to the encoder and the fetch-side decoder.
package instr_encoder_pkg;

    // A type code is the opcode with its two always-set low bits stripped.
    typedef enum logic [4:0] {
        TYPE_LOAD      = 5'b00000,
        TYPE_OP_IMM    = 5'b00100,
        TYPE_AUIPC     = 5'b00101,
        TYPE_OP_IMM_32 = 5'b00110,
        TYPE_STORE     = 5'b01000,
        TYPE_OP        = 5'b01100,
        TYPE_LUI       = 5'b01101,
        TYPE_OP_32     = 5'b01110,
        TYPE_MADD      = 5'b10000,
        TYPE_NMSUB     = 5'b10010,
        TYPE_BRANCH    = 5'b11000,
        TYPE_JALR      = 5'b11001,
        TYPE_JAL       = 5'b11011
    } instr_type_e;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_R4  = 3'd6,
        FMT_ILL = 3'd7
    } instr_fmt_e;

    localparam logic [1:0] OPC_LOW = 2'b11;

    localparam logic [6:0] OPC_LOAD      = {TYPE_LOAD,      OPC_LOW};
    localparam logic [6:0] OPC_OP_IMM    = {TYPE_OP_IMM,    OPC_LOW};
    localparam logic [6:0] OPC_AUIPC     = {TYPE_AUIPC,     OPC_LOW};
    localparam logic [6:0] OPC_OP_IMM_32 = {TYPE_OP_IMM_32, OPC_LOW};
    localparam logic [6:0] OPC_STORE     = {TYPE_STORE,     OPC_LOW};
    localparam logic [6:0] OPC_OP        = {TYPE_OP,        OPC_LOW};
    localparam logic [6:0] OPC_LUI       = {TYPE_LUI,       OPC_LOW};
    localparam logic [6:0] OPC_OP_32     = {TYPE_OP_32,     OPC_LOW};
    localparam logic [6:0] OPC_MADD      = {TYPE_MADD,      OPC_LOW};
    localparam logic [6:0] OPC_NMSUB     = {TYPE_NMSUB,     OPC_LOW};
    localparam logic [6:0] OPC_BRANCH    = {TYPE_BRANCH,    OPC_LOW};
    localparam logic [6:0] OPC_JALR      = {TYPE_JALR,      OPC_LOW};
    localparam logic [6:0] OPC_JAL       = {TYPE_JAL,       OPC_LOW};

    localparam int IMM_I_MIN   = -2048;
    localparam int IMM_I_MAX   = 2047;
    localparam int IMM_B_MIN   = -4096;
    localparam int IMM_B_MAX   = 4094;
    localparam int IMM_J_MIN   = -1048576;
    localparam int IMM_J_MAX   = 1048574;
    localparam int SHAMT64_MAX = 63;
    localparam int SHAMT32_MAX = 31;

    function automatic instr_fmt_e type_format(input logic [4:0] t);
        instr_fmt_e f;
        case (t)
            TYPE_OP, TYPE_OP_32:                                f = FMT_R;
            TYPE_LOAD, TYPE_JALR, TYPE_OP_IMM, TYPE_OP_IMM_32: f = FMT_I;
            TYPE_STORE:                                         f = FMT_S;
            TYPE_BRANCH:                                        f = FMT_B;
            TYPE_AUIPC, TYPE_LUI:                               f = FMT_U;
            TYPE_JAL:                                           f = FMT_J;
            TYPE_MADD, TYPE_NMSUB:                              f = FMT_R4;
            default:                                            f = FMT_ILL;
        endcase
        return f;
    endfunction

    function automatic logic imm_in_range(input logic signed [31:0] v,
                                          input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: type plus decoded fields to one 32-bit word,
// with a per-format immediate legality check. Illegal words come out as zero.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  in_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rs3,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic [31:0] word,
    output logic        err
);

    instr_fmt_e         fmt;
    logic [6:0]         opc;
    logic signed [31:0] simm;
    logic               is_shift;

    assign fmt      = type_format(in_type);
    assign opc      = {in_type, OPC_LOW};
    assign simm     = in_imm;
    assign is_shift = ((in_type == TYPE_OP_IMM) || (in_type == TYPE_OP_IMM_32)) &&
                      ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

    always_comb begin
        word = '0;
        err  = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, opc};
            end
            FMT_I: begin
                if (is_shift && (in_type == TYPE_OP_IMM)) begin
                    // RV64 shamt is 6 bits wide, so imm[5] borrows funct7's low bit.
                    word = {in_funct7[6:1], in_imm[5], in_imm[4:0], in_rs1, in_funct3, in_rd, opc};
                    err  = !imm_in_range(simm, 0, SHAMT64_MAX);
                end else if (is_shift) begin
                    word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, opc};
                    err  = !imm_in_range(simm, 0, SHAMT32_MAX);
                end else begin
                    word = {in_imm[11:0], in_rs1, in_funct3, in_rd, opc};
                    err  = !imm_in_range(simm, IMM_I_MIN, IMM_I_MAX);
                end
            end
            FMT_S: begin
                word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], opc};
                err  = !imm_in_range(simm, IMM_I_MIN, IMM_I_MAX);
            end
            FMT_B: begin
                word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], opc};
                err  = !imm_in_range(simm, IMM_B_MIN, IMM_B_MAX) || in_imm[0];
            end
            FMT_U: begin
                word = {in_imm[31:12], in_rd, opc};
                err  = |in_imm[11:0];
            end
            FMT_J: begin
                word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
                err  = !imm_in_range(simm, IMM_J_MIN, IMM_J_MAX) || in_imm[0];
            end
            FMT_R4: begin
                word = {in_rs3, in_funct7[1:0], in_rs2, in_rs1, in_funct3, in_rd, opc};
            end
            default: begin
                err = 1'b1;
            end
        endcase
        if (err) begin
            word = '0;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: one output register stage with valid/ready,
// a byte-address tag counter and a saturating count of illegal words.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_type,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rs3,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [31:0]          pack_word;
    logic                 pack_err;
    logic                 accept;

    logic                 out_valid_reg, out_valid_next;
    logic [31:0]          out_word_reg,  out_word_next;
    logic [31:0]          out_addr_reg,  out_addr_next;
    logic                 out_err_reg,   out_err_next;
    logic [31:0]          addr_cnt_reg,  addr_cnt_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg,   err_cnt_next;

    instr_pack u_pack (
        .in_type   (in_type),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rs3    (in_rs3),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .word      (pack_word),
        .err       (pack_err)
    );

    // Flush blocks intake so a bundle offered alongside it is dropped, not latched.
    assign in_ready = !flush && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_next = out_valid_reg;
        out_word_next  = out_word_reg;
        out_addr_next  = out_addr_reg;
        out_err_next   = out_err_reg;
        addr_cnt_next  = addr_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        if (flush) begin
            out_valid_next = 1'b0;
            out_word_next  = '0;
            out_addr_next  = BASE_ADDR;
            out_err_next   = 1'b0;
            addr_cnt_next  = BASE_ADDR;
        end else if (accept) begin
            out_valid_next = 1'b1;
            out_word_next  = pack_word;
            out_addr_next  = addr_cnt_reg;
            out_err_next   = pack_err;
            addr_cnt_next  = addr_cnt_reg + 32'd4;
            if (pack_err && (err_cnt_reg != ERR_MAX)) begin
                err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
            out_addr_reg  <= BASE_ADDR;
            out_err_reg   <= 1'b0;
            addr_cnt_reg  <= BASE_ADDR;
            err_cnt_reg   <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_word_reg  <= out_word_next;
            out_addr_reg  <= out_addr_next;
            out_err_reg   <= out_err_next;
            addr_cnt_reg  <= addr_cnt_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_word  = out_word_reg;
    assign out_addr  = out_addr_reg;
    assign out_err   = out_err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, stall, flush,
// saturation and async reset, plus randomized traffic against a reference model.
module tb_instr_encoder;

    localparam int T_LOAD = 0, T_OPIMM = 4, T_AUIPC = 5, T_OPIMM32 = 6, T_STORE = 8;
    localparam int T_OP = 12, T_LUI = 13, T_OP32 = 14, T_MADD = 16, T_NMSUB = 18;
    localparam int T_BRANCH = 24, T_JALR = 25, T_JAL = 27;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_type = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0, in_rs3 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word, out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the output port should show, and the next tag.
    bit        m_valid;
    bit [31:0] m_word, m_addr, m_next;
    bit        m_err;
    int        m_errcnt;

    int valid_types[13] = '{T_LOAD, T_OPIMM, T_AUIPC, T_OPIMM32, T_STORE, T_OP, T_LUI,
                            T_OP32, T_MADD, T_NMSUB, T_BRANCH, T_JALR, T_JAL};

    instr_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rs3    (in_rs3),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Encoding built from field weights, independent of any bit-concatenation view.
    function automatic void ref_encode(input int t, input bit [31:0] rd, rs1, rs2, rs3,
                                       input bit [31:0] f3, f7, input int imm,
                                       output bit [31:0] w, output bit e);
        bit [31:0] u, opc, base_r, hi;
        int lim;
        u = imm;
        opc = t * 4 + 3;
        base_r = (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
        e = 0;
        w = 0;
        if (t == T_OP || t == T_OP32) begin
            w = (f7 << 25) | base_r;
        end else if (t == T_LOAD || t == T_JALR || t == T_OPIMM || t == T_OPIMM32) begin
            if ((t == T_OPIMM || t == T_OPIMM32) && (f3 == 1 || f3 == 5)) begin
                lim = (t == T_OPIMM) ? 63 : 31;
                e = (imm < 0) || (imm > lim);
                hi = (t == T_OPIMM) ? ((f7 & 126) | ((u >> 5) & 1)) : f7;
                w = (hi << 25) | ((u & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
            end else begin
                e = (imm < -2048) || (imm > 2047);
                w = ((u & 4095) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
            end
        end else if (t == T_STORE) begin
            e = (imm < -2048) || (imm > 2047);
            w = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                ((u & 31) << 7) | opc;
        end else if (t == T_BRANCH) begin
            e = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) |
                (rs1 << 15) | (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | opc;
        end else if (t == T_AUIPC || t == T_LUI) begin
            e = (u % 4096) != 0;
            w = ((u / 4096) * 4096) | (rd << 7) | opc;
        end else if (t == T_JAL) begin
            e = (imm < -1048576) || (imm > 1048574) || (imm % 2 != 0);
            w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
                (((u >> 12) & 255) << 12) | (rd << 7) | opc;
        end else if (t == T_MADD || t == T_NMSUB) begin
            w = (rs3 << 27) | ((f7 & 3) << 25) | base_r;
        end else begin
            e = 1;
        end
        if (e) w = 0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_word = 0; m_addr = 0; m_next = 0; m_err = 0; m_errcnt = 0;
    endtask

    // One clock: check in_ready, advance the model at the edge, then check outputs.
    task automatic tick();
        bit exp_ready;
        bit [31:0] w;
        bit e;
        #1;
        exp_ready = !flush && (!m_valid || out_ready);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        ref_encode(int'(in_type), in_rd, in_rs1, in_rs2, in_rs3, in_funct3, in_funct7,
                   int'(in_imm), w, e);
        @(posedge clk);
        if (m_valid && out_ready)
            $display("xfer addr=%h word=%h err=%0d", m_addr, m_word, m_err);
        if (flush) begin
            m_valid = 0;
            m_next = 0;
        end else if (in_valid && exp_ready) begin
            m_valid = 1; m_word = w; m_err = e; m_addr = m_next; m_next = m_next + 4;
            if (e && m_errcnt < 255) m_errcnt++;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("out_word", out_word, m_word);
            check("out_addr", out_addr, m_addr);
            check("out_err", {31'd0, out_err}, {31'd0, m_err});
        end
        check("err_cnt", {24'd0, err_cnt}, m_errcnt);
    endtask

    task automatic drive(input int t, input int rd, rs1, rs2, rs3, f3, f7, input int imm);
        in_valid = 1; in_type = 5'(t); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_rs3 = 5'(rs3); in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
    endtask

    task automatic rand_bundle();
        int t, imm;
        t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                         : valid_types[$urandom_range(0, 12)];
        case ($urandom_range(0, 4))
            0: imm = int'($urandom_range(0, 4200)) - 2100;
            1: imm = int'($urandom_range(0, 9000)) - 4500;
            2: imm = int'($urandom);
            3: imm = int'($urandom & 32'hFFFF_F000);
            default: imm = int'($urandom_range(0, 2100000)) - 1050000;
        endcase
        if ($urandom_range(0, 3) == 0) imm = int'($urandom_range(0, 70));
        drive(t, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127), imm);
    endtask

    task automatic do_flush();
        in_valid = 0; flush = 1; tick(); flush = 0;
    endtask

    int bt[12] = '{T_OPIMM, T_OPIMM, T_OPIMM, T_STORE, T_BRANCH, T_BRANCH, T_BRANCH,
                   T_JAL, T_JAL, T_OPIMM, T_OPIMM32, T_OPIMM32};
    int bf3[12] = '{0, 0, 0, 2, 0, 0, 1, 0, 0, 1, 5, 5};
    int bimm[12] = '{-2048, 2047, 2048, -2049, 4094, 4096, 3, 1048574, -1048576, 63, 31, 32};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_word", out_word, 32'd0);
        check("rst_addr", out_addr, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        out_ready = 1;
        drive(T_OPIMM, 1, 0, 0, 0, 0, 0, 5); tick();
        check("addi_word", out_word, 32'h0050_0093);
        check("addi_addr", out_addr, 32'd0);
        drive(T_LUI, 5, 0, 0, 0, 0, 0, 32'h1234_5000); tick();
        check("lui_word", out_word, 32'h1234_52B7);
        drive(T_LUI, 5, 0, 0, 0, 0, 0, 32'h1234_5001); tick();
        check("lui_bad_word", out_word, 32'd0);
        check("lui_bad_err", {31'd0, out_err}, 32'd1);
        check("lui_bad_cnt", {24'd0, err_cnt}, 32'd1);

        do_flush();
        drive(T_BRANCH, 0, 1, 2, 0, 0, 0, -4); tick();
        check("beq_word", out_word, 32'hFE20_8EE3);
        check("beq_addr", out_addr, 32'd0);
        drive(T_JAL, 1, 0, 0, 0, 0, 0, 2048); tick();
        check("jal_word", out_word, 32'h0010_00EF);
        check("jal_addr", out_addr, 32'd4);

        // Stall: output held while out_ready is low for three cycles.
        do_flush();
        out_ready = 0;
        drive(T_OP, 3, 4, 5, 0, 0, 32, 0); tick();
        drive(T_STORE, 0, 2, 7, 0, 3, 0, -8);
        repeat (3) tick();
        check("stall_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1; tick();
        drive(T_MADD, 9, 1, 2, 3, 7, 2, 0); tick();
        drive(T_OPIMM, 6, 6, 0, 0, 5, 32, 37); tick();
        check("stall_addr3", out_addr, 32'd12);
        in_valid = 0; tick();

        // Flush while a word is held; the flush-cycle bundle is dropped.
        out_ready = 0;
        drive(T_OPIMM, 1, 0, 0, 0, 0, 0, 5); tick();
        flush = 1; drive(T_OP, 1, 2, 3, 0, 0, 0, 0); tick();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 0; out_ready = 1;
        drive(T_JALR, 0, 1, 0, 0, 0, 0, 0); tick();
        check("flush_addr", out_addr, 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(bt[i], 1, 2, 3, 0, bf3[i], 0, bimm[i]);
            tick();
        end

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 7) rand_bundle(); else in_valid = 0;
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 0;

        out_ready = 1;
        for (int i = 0; i < 300; i++) begin
            drive(31, 1, 1, 1, 1, 0, 0, 0);
            tick();
        end
        check("err_sat", {24'd0, err_cnt}, 32'd255);

        // Asynchronous reset pulse between edges while a word is held.
        out_ready = 0;
        drive(T_OPIMM, 2, 2, 0, 0, 0, 0, 100); tick();
        #2;
        rst_n = 0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_word", out_word, 32'd0);
        check("arst_addr", out_addr, 32'd0);
        check("arst_err", {31'd0, out_err}, 32'd0);
        check("arst_errcnt", {24'd0, err_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        drive(T_LUI, 5, 0, 0, 0, 0, 0, 32'h1234_5000); tick();
        check("post_rst_addr", out_addr, 32'd0);
        in_valid = 0; tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
